// File: rtl/wep_decrypt_v1.sv
// WEP frame decryption co-processor: regenerates the RC4 keystream from a 64-bit seed,
// decrypts a ciphertext frame held in DPSRAM, writes back the payload and checks the CRC-32 ICV.
module wep_decrypt_v1 #(
    parameter int ADDR_W    = 16,
    parameter int MAX_FRAME = 2312
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_decrypt,
    input  logic [31:0]       cipher_addr,
    input  logic [31:0]       plain_addr,
    input  logic [31:0]       frame_size,
    input  logic [31:0]       seed_msw,
    input  logic [31:0]       seed_lsw,
    output logic              done,
    output logic              icv_ok,
    output logic              error,
    output logic              port_A_clk,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we
);
    // state | meaning
    // IDLE  | waiting for a start edge
    // SINIT | S[i] = i, one entry per cycle
    // KSA   | key scheduling, one iteration per cycle
    // RD    | ciphertext word address on the port
    // RDW   | read latency cycle, word captured at its end
    // XOR   | one keystream byte per cycle over the word's live lanes
    // WR    | write the recovered word to plaintext
    // CHK   | compare computed ICV against the received one
    // DONE  | result held until reset or a new start
    typedef enum logic [3:0] {IDLE, SINIT, KSA, RD, RDW, XOR, WR, CHK, DONE} state_t;

    state_t            state;
    logic              start_q;
    logic [7:0]        s_box [256];
    logic [7:0]        i_idx, j_idx;
    logic [63:0]       key;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [11:0]       fs_len, pay_len, byte_n;
    logic [31:0]       word_buf, crc, icv_rx;

    logic              start_pulse, bad_frame;
    logic [7:0]        key_byte, ksa_j, i_nx, j_nx, si, sj, t_idx, ks, p_byte;
    logic [1:0]        lane, icv_k;
    logic [11:0]       byte_nx;
    logic              is_pay, word_end, word_pay;
    logic [31:0]       word_nx;
    logic              unused_addr_hi;

    assign port_A_clk     = clk;
    assign unused_addr_hi = ^{cipher_addr[31:ADDR_W], plain_addr[31:ADDR_W]};
    assign start_pulse    = start_decrypt & ~start_q;
    assign bad_frame      = (frame_size < 32'd5) || (frame_size > 32'(MAX_FRAME))
                            || (cipher_addr[1:0] != 2'b00) || (plain_addr[1:0] != 2'b00);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        key_byte = key[{i_idx[2:0], 3'b000} +: 8];
        ksa_j    = j_idx + s_box[i_idx] + key_byte;
        i_nx     = i_idx + 8'd1;
        si       = s_box[i_nx];
        j_nx     = j_idx + si;
        sj       = s_box[j_nx];
        t_idx    = si + sj;
        // keystream byte is read from the array as it stands after this cycle's swap
        if (t_idx == i_nx)
            ks = sj;
        else if (t_idx == j_nx)
            ks = si;
        else
            ks = s_box[t_idx];
        lane     = byte_n[1:0];
        p_byte   = word_buf[{lane, 3'b000} +: 8] ^ ks;
        is_pay   = byte_n < pay_len;
        word_nx  = word_buf;
        if (is_pay)
            word_nx[{lane, 3'b000} +: 8] = p_byte;
        byte_nx  = byte_n + 12'd1;
        word_end = (lane == 2'd3) || (byte_nx == fs_len);
        word_pay = {byte_n[11:2], 2'b00} < pay_len;
        icv_k    = 2'(byte_n - pay_len);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            done           <= 1'b0;
            icv_ok         <= 1'b0;
            error          <= 1'b0;
            port_A_we      <= 1'b0;
            port_A_addr    <= '0;
            port_A_data_in <= '0;
        end else begin
            start_q <= start_decrypt;
            case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        done     <= 1'b0;
                        icv_ok   <= 1'b0;
                        error    <= 1'b0;
                        key      <= {seed_msw, seed_lsw};
                        rd_addr  <= cipher_addr[ADDR_W-1:0];
                        wr_addr  <= plain_addr[ADDR_W-1:0];
                        fs_len   <= frame_size[11:0];
                        pay_len  <= frame_size[11:0] - 12'd4;
                        byte_n   <= '0;
                        crc      <= 32'hFFFFFFFF;
                        icv_rx   <= '0;
                        i_idx    <= '0;
                        if (bad_frame) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state <= SINIT;
                        end
                    end
                end
                SINIT: begin
                    s_box[i_idx] <= i_idx;
                    i_idx        <= i_nx;
                    if (i_idx == 8'hFF) begin
                        j_idx <= '0;
                        state <= KSA;
                    end
                end
                KSA: begin
                    s_box[i_idx] <= s_box[ksa_j];
                    s_box[ksa_j] <= s_box[i_idx];
                    j_idx        <= ksa_j;
                    i_idx        <= i_nx;
                    if (i_idx == 8'hFF) begin
                        j_idx       <= '0;
                        port_A_addr <= rd_addr;
                        rd_addr     <= rd_addr + ADDR_W'(4);
                        state       <= RD;
                    end
                end
                RD:  state <= RDW;
                RDW: begin
                    word_buf <= port_A_data_out;
                    state    <= XOR;
                end
                XOR: begin
                    i_idx       <= i_nx;
                    j_idx       <= j_nx;
                    s_box[i_nx] <= sj;
                    s_box[j_nx] <= si;
                    byte_n      <= byte_nx;
                    word_buf    <= word_nx;
                    if (is_pay)
                        crc <= crc_byte(crc, p_byte);
                    else
                        icv_rx[{icv_k, 3'b000} +: 8] <= p_byte;
                    if (word_end) begin
                        wr_addr <= wr_addr + ADDR_W'(4);
                        if (word_pay) begin
                            port_A_we      <= 1'b1;
                            port_A_addr    <= wr_addr;
                            port_A_data_in <= word_nx;
                            state          <= WR;
                        end else if (byte_nx < fs_len) begin
                            port_A_addr <= rd_addr;
                            rd_addr     <= rd_addr + ADDR_W'(4);
                            state       <= RD;
                        end else begin
                            state <= CHK;
                        end
                    end
                end
                WR: begin
                    port_A_we <= 1'b0;
                    if (byte_n < fs_len) begin
                        port_A_addr <= rd_addr;
                        rd_addr     <= rd_addr + ADDR_W'(4);
                        state       <= RD;
                    end else begin
                        state <= CHK;
                    end
                end
                CHK: begin
                    icv_ok <= (~crc == icv_rx);
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wep_decrypt_v1.sv
// Bench for wep_decrypt_v1: DPSRAM model, behavioural RC4/CRC-32 reference and a
// write-by-write compare process, plus hand-computed literal results for the known vector.
module tb_wep_decrypt_v1;
    localparam logic [63:0] KEY1 = 64'hEFCDAB89_67452301;
    localparam logic [63:0] KEY2 = 64'h0F1E2D3C_4B5A6978;
    localparam logic [63:0] KEY3 = 64'h13579BDF_2468ACE0;

    logic        clk = 1'b0;
    logic        reset, start_decrypt;
    logic [31:0] cipher_addr, plain_addr, frame_size, seed_msw, seed_lsw;
    logic        done, icv_ok, error, port_A_clk, port_A_we;
    logic [31:0] port_A_data_in, port_A_data_out;
    logic [15:0] port_A_addr;

    always #5 clk = ~clk;

    wep_decrypt_v1 dut (
        .clk(clk), .reset(reset), .start_decrypt(start_decrypt),
        .cipher_addr(cipher_addr), .plain_addr(plain_addr), .frame_size(frame_size),
        .seed_msw(seed_msw), .seed_lsw(seed_lsw),
        .done(done), .icv_ok(icv_ok), .error(error), .port_A_clk(port_A_clk),
        .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out),
        .port_A_addr(port_A_addr), .port_A_we(port_A_we)
    );

    logic [31:0] mem [0:16383];
    logic        ld_en = 1'b0;
    logic [13:0] ld_addr;
    logic [31:0] ld_data;

    always @(posedge port_A_clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (port_A_we)
            mem[port_A_addr[15:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    int  wr_count;

    always @(negedge clk) begin : cmp
        wr_t e;
        if (reset === 1'b0) begin
            chk("addr_aligned", {30'd0, port_A_addr[1:0]}, 32'd0);
            if (port_A_we === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {16'd0, port_A_addr}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", {16'd0, port_A_addr}, {16'd0, e.a});
                    chk("write_data", port_A_data_in, e.d);
                end
            end
        end
    end

    logic [7:0] m_ks [0:2311];

    task automatic gen_ks(input logic [63:0] k, input int n);
        int s [256];
        int i, j, t;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'(k[8*(x%8) +: 8])) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int x = 0; x < n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            m_ks[x] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int x = 0; x < 8; x++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic int widx(input logic [31:0] base, input int w);
        logic [31:0] a;
        a = base + 32'(4 * w);
        return int'(a[15:2]);
    endfunction

    task automatic model_frame(input logic [31:0] ca, input logic [31:0] pa, input logic [31:0] fs,
                               input logic [63:0] k, output logic e_err, output logic e_ok);
        logic [31:0] crc, icv, word, wa;
        logic [7:0]  p;
        int n, pay, nw;
        e_err = (fs < 5) || (fs > 2312) || (ca[1:0] != 2'b00) || (pa[1:0] != 2'b00);
        e_ok  = 1'b0;
        if (e_err) return;
        gen_ks(k, int'(fs));
        pay = int'(fs) - 4;
        nw  = (int'(fs) + 3) / 4;
        crc = 32'hFFFFFFFF;
        icv = 32'd0;
        for (int w = 0; w < nw; w++) begin
            word = mem[widx(ca, w)];
            for (int l = 0; l < 4; l++) begin
                n = 4*w + l;
                if (n < int'(fs)) begin
                    p = word[8*l +: 8] ^ m_ks[n];
                    if (n < pay) begin
                        crc = crc_upd(crc, p);
                        word[8*l +: 8] = p;
                    end else begin
                        icv[8*(n-pay) +: 8] = p;
                    end
                end
            end
            wa = pa + 32'(4 * w);
            if (4*w < pay) exp_q.push_back('{a: wa[15:0], d: word});
        end
        e_ok = (~crc == icv);
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        ld_addr = 14'(idx);
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // builds a correctly encrypted frame with a valid ICV from random payload
    task automatic make_frame(input logic [31:0] ca, input int fs, input logic [63:0] k);
        logic [7:0]  pb [0:2315];
        logic [31:0] crc, word;
        int pay, nw;
        gen_ks(k, fs);
        pay = fs - 4;
        nw  = (fs + 3) / 4;
        crc = 32'hFFFFFFFF;
        for (int n = 0; n < pay; n++) begin
            pb[n] = 8'($urandom);
            crc   = crc_upd(crc, pb[n]);
        end
        crc = ~crc;
        for (int x = 0; x < 4; x++) pb[pay + x] = crc[8*x +: 8];
        for (int n = 0; n < fs; n++) pb[n] = pb[n] ^ m_ks[n];
        for (int n = fs; n < 4*nw; n++) pb[n] = 8'($urandom);
        for (int w = 0; w < nw; w++) begin
            word = {pb[4*w+3], pb[4*w+2], pb[4*w+1], pb[4*w]};
            poke(widx(ca, w), word);
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] ca, input logic [31:0] pa,
                             input logic [31:0] fs, input logic [63:0] k, input int hold);
        logic e_err, e_ok, got;
        int   n_exp, limit, cyc;
        model_frame(ca, pa, fs, k, e_err, e_ok);
        n_exp = exp_q.size();
        limit = e_err ? 2 : 520 + 8 * ((int'(fs) + 3) / 4);
        wr_count      = 0;
        cipher_addr   = ca;
        plain_addr    = pa;
        frame_size    = fs;
        seed_msw      = k[63:32];
        seed_lsw      = k[31:0];
        start_decrypt = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (cyc == hold) start_decrypt = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        if (hold != 0) start_decrypt = 1'b0;
        chk({tag, "_done_in_time"}, {31'd0, got}, 32'd1);
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
        chk({tag, "_icv_ok"}, {31'd0, icv_ok}, {31'd0, e_ok});
        chk({tag, "_write_count"}, wr_count, n_exp);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_decrypt = 1'b0;
        cipher_addr = '0; plain_addr = '0; frame_size = '0; seed_msw = '0; seed_lsw = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_icv_ok", {31'd0, icv_ok}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_we", {31'd0, port_A_we}, 32'd0);
        chk("rst_addr", {16'd0, port_A_addr}, 32'd0);
        chk("rst_data_in", port_A_data_in, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        poke(0, 32'hE7C29474);
        poke(1, 32'h584C940C);
        poke(50, 32'hFFFFFFFF);
        run_frame("vec", 32'h0, 32'hC8, 32'd8, KEY1, 2);
        chk("vec_plain_literal", mem[50], 32'h00000000);
        chk("vec_icv_ok_literal", {31'd0, icv_ok}, 32'd1);
        chk("vec_writes_literal", wr_count, 1);

        poke(1, 32'h584C940D);
        poke(50, 32'hFFFFFFFF);
        run_frame("flip", 32'h0, 32'hC8, 32'd8, KEY1, 1);
        chk("flip_plain_literal", mem[50], 32'h00000000);
        chk("flip_icv_ok_literal", {31'd0, icv_ok}, 32'd0);

        poke(1, 32'h584C940C);
        poke(50, 32'hAAAAAAAA);
        run_frame("partial", 32'h0, 32'hC8, 32'd7, KEY1, 1);
        chk("partial_word_literal", mem[50], 32'hE7000000);
        chk("partial_icv_ok_literal", {31'd0, icv_ok}, 32'd0);

        poke(50, 32'hFFFFFFFF);
        run_frame("held", 32'h0, 32'hC8, 32'd8, KEY1, 0);
        repeat (20) @(negedge clk);
        chk("held_done_stays", {31'd0, done}, 32'd1);
        chk("held_single_frame", wr_count, 1);
        chk("held_icv_ok", {31'd0, icv_ok}, 32'd1);
        start_decrypt = 1'b0;
        @(negedge clk);

        run_frame("fs4", 32'h0, 32'hC8, 32'd4, KEY1, 1);
        run_frame("cipher_misalign", 32'h2, 32'hC8, 32'd8, KEY1, 1);
        run_frame("plain_misalign", 32'h0, 32'hCA, 32'd8, KEY1, 1);
        run_frame("fs_too_big", 32'h0, 32'hC8, 32'd2313, KEY1, 1);

        wr_count = 0;
        cipher_addr = 32'h0; plain_addr = 32'hC8; frame_size = 32'd8;
        seed_msw = KEY1[63:32]; seed_lsw = KEY1[31:0];
        start_decrypt = 1'b1;
        @(negedge clk);
        start_decrypt = 1'b0;
        repeat (400) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ksa_rst_no_writes", wr_count, 0);
        chk("ksa_rst_done", {31'd0, done}, 32'd0);
        chk("ksa_rst_we", {31'd0, port_A_we}, 32'd0);
        chk("ksa_rst_addr", {16'd0, port_A_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        poke(50, 32'hFFFFFFFF);
        run_frame("after_rst", 32'h0, 32'hC8, 32'd8, KEY1, 1);
        chk("after_rst_plain_literal", mem[50], 32'h00000000);

        make_frame(32'h100, 5, KEY2);
        run_frame("min5", 32'h100, 32'h200, 32'd5, KEY2, 1);
        chk("min5_icv_ok_literal", {31'd0, icv_ok}, 32'd1);

        make_frame(32'h0001FFF8, 23, KEY2);
        run_frame("wrap_inplace", 32'h0001FFF8, 32'h0001FFF8, 32'd23, KEY2, 1);
        chk("wrap_icv_ok_literal", {31'd0, icv_ok}, 32'd1);

        make_frame(32'h1000, 2312, KEY3);
        run_frame("max", 32'h1000, 32'h4000, 32'd2312, KEY3, 1);
        chk("max_icv_ok_literal", {31'd0, icv_ok}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
